// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch state type.
// The HALT state exists only when FETCH_HALT_EN is defined.
package cpu_pkg;

    localparam int unsigned CpuBits  = 16;
    localparam int unsigned CpuAddrW = 8;

    localparam logic [CpuBits-1:0] CpuHaltOpcode = 16'hFFFF;

`ifdef FETCH_HALT_EN
    typedef enum logic [0:0] {
        StFetch = 1'b0,
        StHalt  = 1'b1
    } fetch_state_e;
`else
    typedef enum logic [0:0] {
        StFetch = 1'b0
    } fetch_state_e;
`endif

endpackage

// File: rtl/fetch_mem_mux.sv
// Memory port arbitration: a load/store request from execute owns the port for its
// cycle; otherwise the port performs an instruction read at the current pc.
module fetch_mem_mux
    import cpu_pkg::*;
#(
    parameter int unsigned BITS   = CpuBits,
    parameter int unsigned ADDR_W = CpuAddrW
) (
    input  logic              i_ls_req,
    input  logic              i_ls_we,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic [BITS-1:0]   i_ls_wdata,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rw,
    output logic [BITS-1:0]   o_mem_wdata
);

    always_comb begin
        o_mem_addr  = i_pc;
        o_mem_rw    = 1'b0;
        o_mem_wdata = '0;
        if (i_ls_req) begin
            o_mem_addr  = i_ls_addr;
            o_mem_rw    = i_ls_we;
            o_mem_wdata = i_ls_wdata;
        end
    end

    // A write must only ever come from an explicit store request.
    always_comb begin
        assert (!o_mem_rw || (i_ls_req && i_ls_we));
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit sharing one memory port with execute load/store traffic.
// Define FETCH_HALT_EN to stop fetching after HALT_OPCODE until the next jump.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       BITS        = CpuBits,
    parameter int unsigned       ADDR_W      = CpuAddrW,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [BITS-1:0]   HALT_OPCODE = BITS'(CpuHaltOpcode)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rw,
    output logic [BITS-1:0]   o_mem_wdata,
    input  logic [BITS-1:0]   i_mem_rdata,
    output logic              o_instr_valid,
    input  logic              i_instr_ready,
    output logic [BITS-1:0]   o_instr,
    output logic [ADDR_W-1:0] o_instr_pc,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_addr,
    input  logic              i_ls_req,
    input  logic              i_ls_we,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic [BITS-1:0]   i_ls_wdata,
    output logic [BITS-1:0]   o_ls_rdata,
    output logic              o_ls_done
);

    fetch_state_e state_q, state_d;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [BITS-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic [BITS-1:0]   ls_rdata_q, ls_rdata_d;
    logic              ls_done_q, ls_done_d;
    logic              fetch_slot;

    fetch_mem_mux #(
        .BITS   (BITS),
        .ADDR_W (ADDR_W)
    ) u_mem_mux (
        .i_ls_req    (i_ls_req),
        .i_ls_we     (i_ls_we),
        .i_ls_addr   (i_ls_addr),
        .i_ls_wdata  (i_ls_wdata),
        .i_pc        (pc_q),
        .o_mem_addr  (o_mem_addr),
        .o_mem_rw    (o_mem_rw),
        .o_mem_wdata (o_mem_wdata)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
`ifdef FETCH_HALT_EN
        unique case (state_q)
            StFetch: begin
                // The halt word itself is still delivered; only later slots stop.
                if (fetch_slot && (i_mem_rdata == HALT_OPCODE)) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (i_jump) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
`endif
    end

`ifndef FETCH_HALT_EN
    logic unused_halt_opcode;
    assign unused_halt_opcode = ^HALT_OPCODE;
`endif

    // Datapath next values and fetch-slot decode
    always_comb begin
        fetch_slot = (state_q == StFetch) && !i_ls_req && !i_jump &&
                     (!instr_valid_q || i_instr_ready);

        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        if (i_jump) begin
            // Redirect wins over everything and flushes any pending instruction.
            pc_d          = i_jump_addr;
            instr_valid_d = 1'b0;
        end else if (fetch_slot) begin
            instr_d       = i_mem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + ADDR_W'(1);
        end else if (instr_valid_q && i_instr_ready) begin
            instr_valid_d = 1'b0;
        end

        ls_done_d  = i_ls_req;
        ls_rdata_d = ls_rdata_q;
        if (i_ls_req && !i_ls_we) begin
            ls_rdata_d = i_mem_rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            ls_rdata_q    <= '0;
            ls_done_q     <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            ls_rdata_q    <= ls_rdata_d;
            ls_done_q     <= ls_done_d;
        end
    end

    assign o_instr       = instr_q;
    assign o_instr_pc    = instr_pc_q;
    assign o_instr_valid = instr_valid_q;
    assign o_ls_rdata    = ls_rdata_q;
    assign o_ls_done     = ls_done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural 256-word memory.
// Build with FETCH_HALT_EN defined to exercise the halt path.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mem_addr;
    logic        mem_rw;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        jump;
    logic [7:0]  jump_addr;
    logic        ls_req;
    logic        ls_we;
    logic [7:0]  ls_addr;
    logic [15:0] ls_wdata;
    logic [15:0] ls_rdata;
    logic        ls_done;

    logic [15:0] mem [256];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_mem_addr    (mem_addr),
        .o_mem_rw      (mem_rw),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata),
        .o_instr_valid (instr_valid),
        .i_instr_ready (instr_ready),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .i_jump        (jump),
        .i_jump_addr   (jump_addr),
        .i_ls_req      (ls_req),
        .i_ls_we       (ls_we),
        .i_ls_addr     (ls_addr),
        .i_ls_wdata    (ls_wdata),
        .o_ls_rdata    (ls_rdata),
        .o_ls_done     (ls_done)
    );

    function automatic logic [15:0] init_word(input int a);
        if (a == 3) return 16'd6490;
        if (a == 5) return 16'hFFFF;
        return 16'hA000 + 16'(a);
    endfunction

    // Memory is (re)loaded while reset is held.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_rw) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; instr_ready = 1'b1; jump = 1'b0; jump_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        step();
        step();
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", 32'(instr), 32'h0);
        check("rst_ipc", 32'(instr_pc), 32'h0);
        check("rst_done", 32'(ls_done), 32'h0);
        check("rst_rdata", 32'(ls_rdata), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_rw", 32'(mem_rw), 32'h0);

        // Streaming fetch from address 0
        rst = 1'b0;
        step();
        check("f0_valid", 32'(instr_valid), 32'h1);
        check("f0_ipc", 32'(instr_pc), 32'h0);
        check("f0_instr", 32'(instr), 32'hA000);
        step();
        check("f1_ipc", 32'(instr_pc), 32'h1);
        step();
        check("f2_ipc", 32'(instr_pc), 32'h2);
        step();
        check("f3_ipc", 32'(instr_pc), 32'h3);
        check("f3_instr", 32'(instr), 32'd6490);

        // Backpressure: hold for three cycles, then resume at pc 4
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", 32'(instr_valid), 32'h1);
            check("stall_ipc", 32'(instr_pc), 32'h3);
            check("stall_instr", 32'(instr), 32'd6490);
            check("stall_pc", 32'(mem_addr), 32'h4);
        end
        instr_ready = 1'b1;
        step();
        check("resume_ipc", 32'(instr_pc), 32'h4);
        check("resume_instr", 32'(instr), 32'hA004);
        step();
        check("halt_word_ipc", 32'(instr_pc), 32'h5);
        check("halt_word_instr", 32'(instr), 32'hFFFF);
        check("halt_word_valid", 32'(instr_valid), 32'h1);
`ifdef FETCH_HALT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            check("halted_valid", 32'(instr_valid), 32'h0);
        end
        jump = 1'b1; jump_addr = 8'd0;
        step();
        check("unhalt_valid", 32'(instr_valid), 32'h0);
        jump = 1'b0;
        step();
        check("unhalt_ipc", 32'(instr_pc), 32'h0);
        check("unhalt_v", 32'(instr_valid), 32'h1);
`else
        step();
        check("nohalt_ipc", 32'(instr_pc), 32'h6);
        check("nohalt_valid", 32'(instr_valid), 32'h1);
`endif

        // Redirect to 20, then store 0x1234 to 10 and load it back
        jump = 1'b1; jump_addr = 8'd20;
        step();
        check("j20_valid", 32'(instr_valid), 32'h0);
        jump = 1'b0;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'd10; ls_wdata = 16'h1234;
        #1;
        check("st_rw", 32'(mem_rw), 32'h1);
        check("st_addr", 32'(mem_addr), 32'd10);
        check("st_wdata", 32'(mem_wdata), 32'h1234);
        step();
        check("st_done", 32'(ls_done), 32'h1);
        check("st_rdata_held", 32'(ls_rdata), 32'h0);
        check("st_no_fetch", 32'(instr_valid), 32'h0);
        ls_we = 1'b0;
        #1;
        check("ld_rw", 32'(mem_rw), 32'h0);
        check("ld_addr", 32'(mem_addr), 32'd10);
        step();
        check("ld_done", 32'(ls_done), 32'h1);
        check("ld_rdata", 32'(ls_rdata), 32'h1234);
        check("ld_no_fetch", 32'(instr_valid), 32'h0);
        ls_req = 1'b0;
        #1;
        check("idle_rw", 32'(mem_rw), 32'h0);
        check("idle_wdata", 32'(mem_wdata), 32'h0);
        check("idle_pc", 32'(mem_addr), 32'd20);
        step();
        check("post_ls_done", 32'(ls_done), 32'h0);
        check("post_ls_ipc", 32'(instr_pc), 32'd20);
        check("post_ls_instr", 32'(instr), 32'hA014);

        // Flush a held instruction by jumping to 255, then wrap to 0
        instr_ready = 1'b0;
        step();
        check("hold20_ipc", 32'(instr_pc), 32'd20);
        jump = 1'b1; jump_addr = 8'd255;
        step();
        check("flush_valid", 32'(instr_valid), 32'h0);
        jump = 1'b0; instr_ready = 1'b1;
        step();
        check("j255_ipc", 32'(instr_pc), 32'd255);
        check("j255_instr", 32'(instr), 32'hA0FF);
        step();
        check("wrap_ipc", 32'(instr_pc), 32'd0);
        check("wrap_instr", 32'(instr), 32'hA000);

        // Jump and load in the same cycle
        jump = 1'b1; jump_addr = 8'd30; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'd3;
        step();
        check("jl_done", 32'(ls_done), 32'h1);
        check("jl_rdata", 32'(ls_rdata), 32'd6490);
        check("jl_valid", 32'(instr_valid), 32'h0);
        jump = 1'b0; ls_req = 1'b0;
        #1;
        check("jl_pc", 32'(mem_addr), 32'd30);
        step();
        check("jl_ipc", 32'(instr_pc), 32'd30);
        check("jl_instr", 32'(instr), 32'hA01E);

        // Reset during a load with an instruction pending
        instr_ready = 1'b0; ls_req = 1'b1; ls_addr = 8'd3; rst = 1'b1;
        step();
        check("mrst_valid", 32'(instr_valid), 32'h0);
        check("mrst_instr", 32'(instr), 32'h0);
        check("mrst_ipc", 32'(instr_pc), 32'h0);
        check("mrst_done", 32'(ls_done), 32'h0);
        check("mrst_rdata", 32'(ls_rdata), 32'h0);
        rst = 1'b0; ls_req = 1'b0; instr_ready = 1'b1;
        #1;
        check("mrst_pc", 32'(mem_addr), 32'h0);
        step();
        check("mrst_no_done", 32'(ls_done), 32'h0);
        check("mrst_f_ipc", 32'(instr_pc), 32'h0);
        check("mrst_f_valid", 32'(instr_valid), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
